// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM receive demultiplexer: FSM state encoding,
// counter control bundle and the width helper macro.
`ifndef TDM_CLOG2
`define TDM_CLOG2(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic clr;
    logic load1;
    logic en;
  } cnt_ctl_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-N_CH slot counter giving the index of the next expected beat.
// Priority: clear, then load-1, then increment with wrap.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = `TDM_CLOG2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [SEL_W-1:0] sel,
  output logic             last_slot
);

  assign last_slot = (sel == SEL_W'(N_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (clr) begin
      sel <= '0;
    end else if (load1) begin
      sel <= SEL_W'(1);
    end else if (en) begin
      sel <= last_slot ? '0 : sel + SEL_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: collects one word per slot into a shadow
// buffer and publishes a complete frame on ch_data in a single edge.
//
// state  | meaning
// HUNT   | waiting for a valid beat carrying frame_sync
// LOCKED | aligned; sel tracks the slot of the next expected beat
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int SEL_W = `TDM_CLOG2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        din,
  input  logic                din_valid,
  input  logic                frame_sync,
  output logic [N_CH*W-1:0]   ch_data,
  output logic                frame_valid,
  output logic [SEL_W-1:0]    sel,
  output logic                locked,
  output logic                sync_err
);

  state_t                   state;
  cnt_ctl_t                 cnt_ctl;
  logic                     last_slot;
  logic [N_CH-2:0][W-1:0]   shadow;

  tdm_slot_counter #(.N_CH(N_CH)) u_slot_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_ctl.clr),
    .load1     (cnt_ctl.load1),
    .en        (cnt_ctl.en),
    .sel       (sel),
    .last_slot (last_slot)
  );

  // Any sync beat restarts the frame at slot 1; a missing sync at slot 0 drops lock.
  always_comb begin
    cnt_ctl = '0;
    if (din_valid) begin
      if (state == HUNT) begin
        cnt_ctl.load1 = frame_sync;
      end else if (frame_sync) begin
        cnt_ctl.load1 = 1'b1;
      end else if (sel == '0) begin
        cnt_ctl.clr = 1'b1;
      end else begin
        cnt_ctl.en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      locked      <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      shadow      <= '0;
      ch_data     <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (frame_sync) begin
            shadow[0] <= din;
            state     <= LOCKED;
            locked    <= 1'b1;
          end
        end else if (frame_sync) begin
          // Early sync discards the partial frame; the beat becomes slot 0.
          shadow[0] <= din;
          if (sel != '0) begin
            sync_err <= 1'b1;
          end
        end else if (sel == '0) begin
          sync_err <= 1'b1;
          state    <= HUNT;
          locked   <= 1'b0;
        end else if (last_slot) begin
          ch_data     <= {din, shadow};
          frame_valid <= 1'b1;
        end else begin
          for (int k = 1; k < N_CH - 1; k++) begin
            if (sel == SEL_W'(k)) begin
              shadow[k] <= din;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (N_CH=4, W=8): a frame-level reference model
// predicts frames and framing errors; a negedge monitor checks every cycle.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [W-1:0]        din;
  logic                din_valid;
  logic                frame_sync;
  logic [N_CH*W-1:0]   ch_data;
  logic                frame_valid;
  logic [1:0]          sel;
  logic                locked;
  logic                sync_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              is_frame;
    logic [N_CH*W-1:0] data;
  } ev_t;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];

  // Reference model: partial frame as a list of words, plus the last published frame.
  int unsigned     cur[$];
  bit              m_locked = 0;
  logic [N_CH*W-1:0] m_ch = '0;
  int              frames_seen = 0;
  int              errs_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit s, input logic [W-1:0] d);
    ev_t e;
    if (!m_locked) begin
      if (s) begin
        cur.delete();
        cur.push_back(d);
        m_locked = 1;
      end
    end else if (s) begin
      if (cur.size() != 0) begin
        e.is_frame = 0; e.data = '0; exp_q.push_back(e);
      end
      cur.delete();
      cur.push_back(d);
    end else if (cur.size() == 0) begin
      e.is_frame = 0; e.data = '0; exp_q.push_back(e);
      m_locked = 0;
    end else begin
      cur.push_back(d);
      if (cur.size() == N_CH) begin
        m_ch = '0;
        for (int i = 0; i < N_CH; i++) m_ch += (N_CH*W)'(cur[i]) << (i * W);
        e.is_frame = 1; e.data = m_ch; exp_q.push_back(e);
        cur.delete();
      end
    end
  endfunction

  task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    if (rst_n && v) model_step(s, d);
    #1;
  endtask

  task automatic frame(input logic [W-1:0] d0, d1, d2, d3);
    beat(1, 1, d0); beat(1, 0, d1); beat(1, 0, d2); beat(1, 0, d3);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    din_valid = 1'b0;
    cur.delete();
    m_locked = 0;
    m_ch = '0;
    exp_q.delete();
    #1;
    chk("rst_ch_data", ch_data, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sel", sel, 0);
    chk("rst_sync_err", sync_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ev_t e;
    chk("pulse_overlap", frame_valid & sync_err, 0);
    chk("pulse_present", frame_valid | sync_err, exp_q.size() != 0);
    if ((frame_valid || sync_err) && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pulse_kind", frame_valid, e.is_frame);
      if (e.is_frame) begin
        chk("frame_data", ch_data, e.data);
        frames_seen++;
      end else begin
        errs_seen++;
      end
    end
    chk("locked", locked, m_locked);
    chk("sel", sel, cur.size());
    chk("ch_data", ch_data, m_ch);
  end

  initial begin
    int fv_cnt;
    bit s;
    rst_n = 1'b0; din_valid = 0; frame_sync = 0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: clean frame
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_ch_data", ch_data, 32'h44332211);
    chk("t1_locked", locked, 1);
    chk("t1_sel", sel, 0);
    beat(0, 0, 8'h00);
    chk("t1_fv_one_cycle", frame_valid, 0);

    // 2: unsynced beat in HUNT is dropped silently
    pulse_reset();
    beat(1, 0, 8'hA1);
    chk("t2_sync_err", sync_err, 0);
    chk("t2_locked", locked, 0);
    chk("t2_ch_data", ch_data, 0);

    // 3: early sync restarts the frame
    beat(1, 1, 8'h01); beat(1, 0, 8'h02);
    beat(1, 1, 8'h55);
    chk("t3_sync_err", sync_err, 1);
    beat(1, 0, 8'h66); beat(1, 0, 8'h77); beat(1, 0, 8'h88);
    chk("t3_ch_data", ch_data, 32'h88776655);

    // 4: missing sync on slot 0 drops lock, keeps last frame
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    beat(1, 0, 8'h99);
    chk("t4_sync_err", sync_err, 1);
    chk("t4_locked", locked, 0);
    chk("t4_sel", sel, 0);
    chk("t4_ch_data", ch_data, 32'hC4C3C2C1);

    // 5: gaps inside a frame
    beat(1, 1, 8'h11); beat(0, 0, 8'hEE);
    beat(1, 0, 8'h22); repeat (3) beat(0, 1, 8'hEE);
    beat(1, 0, 8'h33); repeat (2) beat(0, 0, 8'hEE);
    beat(1, 0, 8'h44);
    chk("t5_frame_valid", frame_valid, 1);
    chk("t5_ch_data", ch_data, 32'h44332211);

    // 6: back-to-back frames with reset mid-frame-2
    fv_cnt = 0;
    beat(1, 1, 8'h10); beat(1, 0, 8'h20); beat(1, 0, 8'h30); beat(1, 0, 8'h40);
    fv_cnt += frame_valid;
    beat(1, 1, 8'h50);
    fv_cnt += frame_valid;
    beat(1, 0, 8'h60);
    chk("t6_rate", fv_cnt, 1);
    pulse_reset();
    frame(8'hF1, 8'hF2, 8'hF3, 8'hF4);
    chk("t6_frame3", ch_data, 32'hF4F3F2F1);
    chk("t6_locked", locked, 1);

    // Random traffic: mostly well-formed frames, occasional framing faults and gaps.
    for (int i = 0; i < 3000; i++) begin
      if (cur.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                 s = ($urandom_range(0, 19) == 0);
      beat($urandom_range(0, 3) != 0, s, W'($urandom));
      if (i == 1500) pulse_reset();
    end
    beat(0, 0, 8'h00);
    beat(0, 0, 8'h00);
    chk("queue_drained", exp_q.size(), 0);
    chk("saw_frames", frames_seen > 20, 1);
    chk("saw_errors", errs_seen > 5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
